// File: rtl/mux_word_serializer_pkg.sv
// Shared definitions for the 8-bit parallel-to-serial front end.
//   SER_WIDTH : bits per word
//   SEL_W     : width of the mux select counter (s2..s0)
//   state_e   : control FSM states
//   sel_first / sel_last : select values that start and end a word for a given bit order
package mux_word_serializer_pkg;

  localparam int SER_WIDTH = 8;
  localparam int SEL_W     = 3;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic sel_t sel_first(input bit msb_first);
    return msb_first ? sel_t'(SER_WIDTH - 1) : sel_t'(0);
  endfunction

  function automatic sel_t sel_last(input bit msb_first);
    return msb_first ? sel_t'(0) : sel_t'(SER_WIDTH - 1);
  endfunction

endpackage

// File: rtl/mux_word_serializer_mux.sv
// The team's 8-to-1 mux (_8x1Mux): res follows the data input chosen by {s2,s1,s0}.
//   a..h   in  data inputs, {s2,s1,s0}=0 selects a, 7 selects h
//   s0..s2 in  select, s0 is the LSB
//   res    out selected data bit
module mux_word_serializer_mux (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic e,
  input  logic f,
  input  logic g,
  input  logic h,
  input  logic s0,
  input  logic s1,
  input  logic s2,
  output logic res
);

  always_comb begin
    case ({s2, s1, s0})
      3'd0:    res = a;
      3'd1:    res = b;
      3'd2:    res = c;
      3'd3:    res = d;
      3'd4:    res = e;
      3'd5:    res = f;
      3'd6:    res = g;
      default: res = h;
    endcase
  end

endmodule

// File: rtl/mux_word_serializer.sv
// Parallel-to-serial front end for the 8-to-1 mux.
// Takes an 8-bit word on a valid/ready handshake, parks it on the mux data inputs and
// walks the select counter across it, presenting one bit per cycle on a valid/ready
// serial stream. Back-to-back words run without a bubble.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/in_valid/in_ready     word input handshake
//   ser_bit/ser_valid/ser_last/ser_ready   serial output handshake
//   word_cnt              completed words, mod 256
// Parameters: MSB_FIRST (0: bit0 first, 1: bit7 first), IDLE_VAL (ser_bit when idle).
module mux_word_serializer
  import mux_word_serializer_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0,
  parameter bit IDLE_VAL  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SER_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 ser_bit,
  output logic                 ser_valid,
  output logic                 ser_last,
  input  logic                 ser_ready,
  output logic [7:0]           word_cnt
);

  localparam sel_t SEL_FIRST = sel_first(MSB_FIRST);
  localparam sel_t SEL_LAST  = sel_last(MSB_FIRST);

  state_e               state_q, state_d;
  logic [SER_WIDTH-1:0] data_q, data_d;
  sel_t                 sel_q, sel_d;
  logic [7:0]           word_cnt_q, word_cnt_d;
  logic                 at_last;
  logic                 mux_res;

  mux_word_serializer_mux u_mux (
    .a   (data_q[0]),
    .b   (data_q[1]),
    .c   (data_q[2]),
    .d   (data_q[3]),
    .e   (data_q[4]),
    .f   (data_q[5]),
    .g   (data_q[6]),
    .h   (data_q[7]),
    .s0  (sel_q[0]),
    .s1  (sel_q[1]),
    .s2  (sel_q[2]),
    .res (mux_res)
  );

  // Serial outputs come only from registered state, so in_* never reaches ser_*.
  assign at_last   = (sel_q == SEL_LAST);
  assign ser_valid = (state_q == ST_SHIFT);
  assign ser_last  = ser_valid & at_last;
  assign ser_bit   = ser_valid ? mux_res : IDLE_VAL;
  assign word_cnt  = word_cnt_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    state_d    = state_q;
    data_d     = data_q;
    sel_d      = sel_q;
    word_cnt_d = word_cnt_q;
    in_ready   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          sel_d   = SEL_FIRST;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ser_ready) begin
          if (at_last) begin
            // Final bit leaves this cycle: the slot is free for the next word,
            // which is loaded on the same edge to avoid an idle bubble.
            in_ready   = 1'b1;
            word_cnt_d = word_cnt_q + 8'd1;
            if (in_valid) begin
              data_d = in_data;
              sel_d  = SEL_FIRST;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            sel_d = MSB_FIRST ? sel_q - sel_t'(1) : sel_q + sel_t'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      sel_q      <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_mux_word_serializer.sv
// Bench for mux_word_serializer: one LSB-first instance (IDLE_VAL=0) and one MSB-first
// instance (IDLE_VAL=1) share the same input stimulus; a bit-queue model predicts both.
module tb_mux_word_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       ser_ready = 1'b0;

  logic       l_in_ready, l_bit, l_valid, l_last;
  logic [7:0] l_cnt;
  logic       m_in_ready, m_bit, m_valid, m_last;
  logic [7:0] m_cnt_o;

  mux_word_serializer #(.MSB_FIRST(1'b0), .IDLE_VAL(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(l_in_ready), .ser_bit(l_bit), .ser_valid(l_valid), .ser_last(l_last),
    .ser_ready(ser_ready), .word_cnt(l_cnt)
  );

  mux_word_serializer #(.MSB_FIRST(1'b1), .IDLE_VAL(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(m_in_ready), .ser_bit(m_bit), .ser_valid(m_valid), .ser_last(m_last),
    .ser_ready(ser_ready), .word_cnt(m_cnt_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: bits still to be sent, in transmission order, per bit order.
  bit lsb_q[$];
  bit msb_q[$];
  int model_cnt = 0;

  // Bits actually handed downstream (valid & ready), per instance.
  bit got_lsb[$];
  bit got_msb[$];

  // Output samples taken at the falling edge of the last cycle() call.
  logic [1:0] smp_valid, smp_last, smp_bit, smp_rdy;
  logic [2:0] smp_sel_l, smp_sel_m;

  typedef struct {
    logic [7:0] d;
    logic       v, r;
    logic       e_valid, e_last, e_rdy, e_lsb, e_msb;
    logic [2:0] e_sel_msb;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model at the falling edge,
  // then advance the model at the rising edge.
  task automatic cycle(input logic [7:0] d, input logic v, input logic r);
    bit e_valid, e_last, e_rdy, was_last;
    int sz;
    in_data = d; in_valid = v; ser_ready = r;
    @(negedge clk);
    sz      = lsb_q.size();
    e_valid = (sz != 0);
    e_last  = (sz == 1);
    e_rdy   = (sz == 0) || (sz == 1 && r);
    smp_valid = {m_valid, l_valid};
    smp_last  = {m_last, l_last};
    smp_bit   = {m_bit, l_bit};
    smp_rdy   = {m_in_ready, l_in_ready};
    smp_sel_l = dut_lsb.sel_q;
    smp_sel_m = dut_msb.sel_q;
    check("lsb ser_valid", 32'(l_valid), 32'(e_valid));
    check("msb ser_valid", 32'(m_valid), 32'(e_valid));
    check("lsb ser_last", 32'(l_last), 32'(e_last));
    check("msb ser_last", 32'(m_last), 32'(e_last));
    check("lsb in_ready", 32'(l_in_ready), 32'(e_rdy));
    check("msb in_ready", 32'(m_in_ready), 32'(e_rdy));
    check("lsb ser_bit", 32'(l_bit), 32'(e_valid ? lsb_q[0] : 1'b0));
    check("msb ser_bit", 32'(m_bit), 32'(e_valid ? msb_q[0] : 1'b1));
    check("lsb word_cnt", 32'(l_cnt), 32'(model_cnt));
    check("msb word_cnt", 32'(m_cnt_o), 32'(model_cnt));
    if (e_valid) begin
      check("lsb sel", 32'(smp_sel_l), 32'(8 - sz));
      check("msb sel", 32'(smp_sel_m), 32'(sz - 1));
    end
    if (l_valid && r) got_lsb.push_back(l_bit);
    if (m_valid && r) got_msb.push_back(m_bit);
    @(posedge clk);
    was_last = (sz == 1) && r;
    if (sz != 0 && r) begin
      void'(lsb_q.pop_front());
      void'(msb_q.pop_front());
    end
    if (was_last) model_cnt = (model_cnt + 1) % 256;
    if (e_rdy && v) begin
      for (int i = 0; i < 8; i++) begin
        lsb_q.push_back(d[i]);
        msb_q.push_back(d[7-i]);
      end
    end
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must react before any clock edge.
  task automatic do_reset();
    in_valid = 1'b0; ser_ready = 1'b0; in_data = 8'h00;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst lsb ser_valid", 32'(l_valid), 32'd0);
    check("rst msb ser_valid", 32'(m_valid), 32'd0);
    check("rst lsb in_ready", 32'(l_in_ready), 32'd1);
    check("rst msb in_ready", 32'(m_in_ready), 32'd1);
    check("rst lsb word_cnt", 32'(l_cnt), 32'd0);
    check("rst msb word_cnt", 32'(m_cnt_o), 32'd0);
    check("rst lsb ser_bit", 32'(l_bit), 32'd0);
    check("rst msb ser_bit", 32'(m_bit), 32'd1);
    check("rst lsb ser_last", 32'(l_last), 32'd0);
    lsb_q.delete();
    msb_q.delete();
    model_cnt = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Reassemble the collected bits into a word and compare with the word sent.
  task automatic check_words(input string name, input logic [7:0] exp);
    logic [7:0] wl, wm;
    wl = 8'h00; wm = 8'h00;
    check({name, " lsb bit count"}, 32'(got_lsb.size()), 32'd8);
    check({name, " msb bit count"}, 32'(got_msb.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_lsb.size(); i++) wl[i] = got_lsb[i];
    for (int i = 0; i < 8 && i < got_msb.size(); i++) wm[7-i] = got_msb[i];
    check({name, " lsb word"}, 32'(wl), 32'(exp));
    check({name, " msb word"}, 32'(wm), 32'(exp));
    got_lsb.delete();
    got_msb.delete();
  endtask

  initial begin
    logic [7:0] words [2];
    logic [7:0] w;
    vec_t       row;
    int         vcnt, rcnt, rat;

    // Directed table: 8'hA5 then 8'h01, full-rate, each followed by an idle cycle.
    words[0] = 8'hA5;
    words[1] = 8'h01;
    for (int n = 0; n < 2; n++) begin
      w = words[n];
      row = '{d: w, v: 1'b1, r: 1'b1, e_valid: 1'b0, e_last: 1'b0, e_rdy: 1'b1,
              e_lsb: 1'b0, e_msb: 1'b1, e_sel_msb: 3'd0};
      tbl.push_back(row);
      for (int k = 0; k < 8; k++) begin
        row = '{d: 8'h00, v: 1'b0, r: 1'b1, e_valid: 1'b1, e_last: (k == 7),
                e_rdy: (k == 7), e_lsb: w[k], e_msb: w[7-k], e_sel_msb: 3'(7 - k)};
        tbl.push_back(row);
      end
    end

    do_reset();

    foreach (tbl[i]) begin
      cycle(tbl[i].d, tbl[i].v, tbl[i].r);
      check($sformatf("tbl%0d valid", i), 32'(smp_valid), {30'd0, {2{tbl[i].e_valid}}});
      check($sformatf("tbl%0d last", i), 32'(smp_last), {30'd0, {2{tbl[i].e_last}}});
      check($sformatf("tbl%0d in_ready", i), 32'(smp_rdy), {30'd0, {2{tbl[i].e_rdy}}});
      check($sformatf("tbl%0d bits", i), 32'(smp_bit), {30'd0, tbl[i].e_msb, tbl[i].e_lsb});
      if (tbl[i].e_valid)
        check($sformatf("tbl%0d msb sel", i), 32'(smp_sel_m), 32'(tbl[i].e_sel_msb));
    end
    check("tbl word_cnt lsb", 32'(l_cnt), 32'd2);
    check("tbl word_cnt msb", 32'(m_cnt_o), 32'd2);
    got_lsb.delete();
    got_msb.delete();

    // Stall for three cycles on the fourth bit of 8'hF0.
    cycle(8'hF0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) cycle(8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(8'h00, 1'b0, 1'b0);
      check("stall lsb sel", 32'(dut_lsb.sel_q), 32'd3);
      check("stall msb sel", 32'(dut_msb.sel_q), 32'd4);
      check("stall lsb bit", 32'(l_bit), 32'd0);
      check("stall msb bit", 32'(m_bit), 32'd1);
      check("stall valid", 32'({m_valid, l_valid}), 32'd3);
    end
    for (int k = 0; k < 5; k++) cycle(8'h00, 1'b0, 1'b1);
    check_words("stall", 8'hF0);

    // Back-to-back 8'hFF then 8'h00 with in_valid held through the first word.
    do_reset();
    vcnt = 0; rcnt = 0; rat = -1;
    cycle(8'hFF, 1'b1, 1'b1);
    for (int c = 1; c <= 16; c++) begin
      cycle(8'h00, (c <= 8), 1'b1);
      if (smp_valid == 2'b11) vcnt++;
      if (c <= 15 && smp_rdy[0]) begin
        rcnt++;
        rat = c;
      end
    end
    check("b2b valid cycles", 32'(vcnt), 32'd16);
    check("b2b in_ready pulses", 32'(rcnt), 32'd1);
    check("b2b in_ready cycle", 32'(rat), 32'd8);
    check("b2b word_cnt lsb", 32'(l_cnt), 32'd2);
    check("b2b word_cnt msb", 32'(m_cnt_o), 32'd2);
    cycle(8'h00, 1'b0, 1'b1);
    got_lsb.delete();
    got_msb.delete();

    // Reset in the middle of a word, then a fresh word.
    cycle(8'h5A, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) cycle(8'h00, 1'b0, 1'b1);
    got_lsb.delete();
    got_msb.delete();
    do_reset();
    for (int k = 0; k < 4; k++) cycle(8'h00, 1'b0, 1'b1);
    check("post-reset leftover lsb", 32'(got_lsb.size()), 32'd0);
    check("post-reset leftover msb", 32'(got_msb.size()), 32'd0);
    cycle(8'h3C, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) cycle(8'h00, 1'b0, 1'b1);
    check_words("after reset", 8'h3C);
    check("after reset word_cnt", 32'(l_cnt), 32'd1);

    // Randomized traffic with random downstream backpressure.
    for (int n = 0; n < 600; n++)
      cycle(8'($urandom), ($urandom_range(3) != 0), ($urandom_range(2) != 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
